// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   - tx_state_e : transmitter FSM state encoding (exposed on the debug port)
//   - PAR_NONE / PAR_EVEN / PAR_ODD : values of the PARITY parameter
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd5
   } tx_state_e;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered_if
// Bus-side bundle of the buffered UART transmitter.
//   DataIn/InValid/InReady : write handshake. A word transfers on a Clock edge
//                            where InValid && InReady are both high. InReady is
//                            "FIFO not full"; it never depends on InValid.
//                            InValid while InReady is low is simply ignored
//                            (the word is dropped), so a source may hold it.
//   Transmit               : serial line, idle high
//   Busy                   : frame in progress or words still queued
//   Level                  : FIFO occupancy
// modport master : the word source (CPU side / testbench)
// modport slave  : the transmitter
// -----------------------------------------------------------------------------
interface uart_tx_buffered_if #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_WIDTH-1:0] DataIn;
   logic                  InValid;
   logic                  InReady;
   logic                  Transmit;
   logic                  Busy;
   logic [LVL_W-1:0]      Level;

   modport master (
      output DataIn, InValid,
      input  InReady, Transmit, Busy, Level
   );

   modport slave (
      input  DataIn, InValid,
      output InReady, Transmit, Busy, Level
   );
endinterface

// File: rtl/tx_fifo.sv
// -----------------------------------------------------------------------------
// tx_fifo
// Synchronous FIFO holding words waiting to be serialised.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   i_push, i_data : write request / word; ignored while full
//   i_pop          : read request; ignored while empty
//   o_data         : head word (combinational read of the head entry)
//   o_full,o_empty : status, both based on the pre-edge occupancy
//   o_level        : occupancy 0..FIFO_DEPTH
// FIFO_DEPTH must be a power of two so the pointers wrap naturally; the level
// counter is what tells full from empty when the pointers are equal.
// -----------------------------------------------------------------------------
module tx_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_push,
   input  logic [DATA_WIDTH-1:0]             i_data,
   input  logic                              i_pop,
   output logic [DATA_WIDTH-1:0]             o_data,
   output logic                              o_full,
   output logic                              o_empty,
   output logic [$clog2(FIFO_DEPTH):0]       o_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [LW-1:0]         r_level;
   logic                  w_push_ok;
   logic                  w_pop_ok;

   assign o_full    = (r_level == LW'(FIFO_DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_data    = r_mem[r_rd_ptr];

   // A push on the same edge as a pop is still refused when full: o_full is
   // the pre-edge state, so a full FIFO never overwrites the head being read.
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop  && !o_empty;

   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// Buffered asynchronous serial transmitter. Words enter a FIFO over the bus
// handshake and leave LSB-first as frames: start(0), data, [parity], stop(1).
// Each bit lasts one BaudTick-to-BaudTick interval.
// Ports:
//   Clock, Reset_n : clock, asynchronous active-low reset (aborts any frame,
//                    flushes the FIFO, drives the line high at once)
//   BaudTick       : one-cycle pulse per bit period
//   bus            : uart_tx_buffered_if.slave (DataIn/InValid/InReady,
//                    Transmit/Busy/Level)
//   o_dbg_state    : current FSM state
// Parameters: DATA_WIDTH (1..16), FIFO_DEPTH (power of two, >=2),
//   STOP_BITS (1 or 2), PARITY (PAR_NONE/PAR_EVEN/PAR_ODD).
// Optional feature macro: UART_TX_PARITY_EN. Without it no parity state or
// logic is built and PARITY is ignored.
// -----------------------------------------------------------------------------
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1,
   parameter int PARITY     = 0
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic               BaudTick,
   uart_tx_buffered_if.slave  bus,
   output tx_state_e          o_dbg_state
);
   localparam int                 LVL_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int                 CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
   localparam logic               LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_e             r_state;
   tx_state_e             w_state_next;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [CNT_W-1:0]      w_bit_cnt_next;
   logic                  r_stop_cnt;
   logic                  w_stop_cnt_next;
   logic                  r_tx;
   logic                  w_tx_next;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_fifo_data;
   logic                  w_full;
   logic                  w_empty;
   logic [LVL_W-1:0]      w_level;

   tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (Clock),
      .i_rst_n (Reset_n),
      .i_push  (bus.InValid),
      .i_data  (bus.DataIn),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

`ifdef UART_TX_PARITY_EN
   localparam bit HAS_PAR = (PARITY != PAR_NONE);

   // Parity of the word is captured as it is popped, so the PARITY bit does
   // not depend on the (by then shifted) data register.
   logic r_parity;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_parity <= 1'b0;
      end else if (w_pop) begin
         r_parity <= (^w_fifo_data) ^ (PARITY == PAR_ODD);
      end
   end
`else
   logic w_unused_parity;
   assign w_unused_parity = (PARITY != PAR_NONE);
`endif

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_shift    <= w_shift_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_stop_cnt <= w_stop_cnt_next;
         r_tx       <= w_tx_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_shift_next    = r_shift;
      w_bit_cnt_next  = r_bit_cnt;
      w_stop_cnt_next = r_stop_cnt;
      w_pop           = 1'b0;
      w_tx_next       = 1'b1;

      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop          = 1'b1;
               w_shift_next   = w_fifo_data;
               w_bit_cnt_next = '0;
               w_state_next   = ST_ARM;
            end
         end
         // ARM waits for a tick so the start bit is a full bit period long.
         ST_ARM: begin
            if (BaudTick) w_state_next = ST_START;
         end
         ST_START: begin
            if (BaudTick) w_state_next = ST_DATA;
         end
         ST_DATA: begin
            if (BaudTick) begin
               if (r_bit_cnt == LAST_BIT) begin
                  w_stop_cnt_next = 1'b0;
`ifdef UART_TX_PARITY_EN
                  w_state_next    = HAS_PAR ? ST_PARITY : ST_STOP;
`else
                  w_state_next    = ST_STOP;
`endif
               end else begin
                  w_shift_next   = r_shift >> 1;
                  w_bit_cnt_next = r_bit_cnt + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (BaudTick) begin
               w_stop_cnt_next = 1'b0;
               w_state_next    = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (BaudTick) begin
               if (r_stop_cnt == LAST_STOP) begin
                  // Queued word: go straight to its start bit, no ARM gap.
                  if (!w_empty) begin
                     w_pop          = 1'b1;
                     w_shift_next   = w_fifo_data;
                     w_bit_cnt_next = '0;
                     w_state_next   = ST_START;
                  end else begin
                     w_state_next   = ST_IDLE;
                  end
               end else begin
                  w_stop_cnt_next = r_stop_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      // The line register takes the level of the state being entered, so it
      // only ever changes on the edges where the FSM advances on a tick.
      case (w_state_next)
         ST_START:  w_tx_next = 1'b0;
         ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_tx_next = r_parity;
`endif
         default:   w_tx_next = 1'b1;
      endcase
   end

   assign bus.InReady  = !w_full;
   assign bus.Transmit = r_tx;
   assign bus.Busy     = (r_state != ST_IDLE) || (w_level != '0);
   assign bus.Level    = w_level;
   assign o_dbg_state  = r_state;

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised, buffered serial transmitter: accepts words over a valid/ready handshake into an internal FIFO and shifts each word out LSB-first as an asynchronous serial frame (start, data, optional parity, stop) paced by an external baud tick. It replaces the single-word, unbuffered transmitter on the serial output path, so the CPU-side bus can queue several words without polling Busy between them. The baud-tick generator upstream is unchanged.

## Interface
- DATA_WIDTH, 16: data bits per frame (1..16).
- FIFO_DEPTH, 4: buffered words; power of two, >= 2.
- STOP_BITS, 1: stop bits per frame (1 or 2).
- PARITY, 0: 0 none, 1 even, 2 odd; honoured only under UART_TX_PARITY_EN.
- Clock  in  1  single clock; all state on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- BaudTick  in  1  one-Clock-wide pulse per bit period.
- DataIn  in  DATA_WIDTH  word to queue.
- InValid  in  1  DataIn valid this cycle.
- InReady  out  1  FIFO can accept a word (= not full).
- Transmit  out  1  serial line, idle high, registered.
- Busy  out  1  frame in progress or FIFO non-empty.
- Level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Push: word written when InValid && InReady on a Clock edge. InValid while full is ignored (word dropped, no error flag).
- FSM states: IDLE, ARM, START, DATA, PARITY, STOP.
- IDLE: Transmit=1. If FIFO non-empty: pop head into shift register, bit counter=0, go ARM.
- ARM: Transmit=1; on BaudTick go START (aligns frame to tick grid).
- START: Transmit=0; on BaudTick go DATA.
- DATA: Transmit=shift[0]; on BaudTick shift right, counter+1; after bit DATA_WIDTH-1 go PARITY (if enabled) else STOP.
- PARITY: Transmit = XOR of word (even) or its inverse (odd); on BaudTick go STOP.
- STOP: Transmit=1 for STOP_BITS ticks, then IDLE if FIFO empty, else pop next word and go directly to START (back-to-back frames, no ARM gap).
- Parity computed over the word at pop time, held in a register.
- Busy = (state != IDLE) || (Level != 0).
- Simultaneous push and pop: both occur; Level unchanged. Push into full FIFO on the same cycle as a pop is refused (InReady reflects pre-edge state).
- FIFO pointers wrap modulo FIFO_DEPTH; Level distinguishes full from empty.
- Reset mid-frame: frame aborted, FIFO flushed, Transmit returns high immediately.

## Timing
- Reset values: Transmit=1, Busy=0, InReady=1, Level=0, FSM=IDLE.
- Push to Level update: 1 cycle. Push into empty idle block to pop: 1 cycle later (IDLE samples non-empty).
- Start bit begins on the Clock edge of the first BaudTick after ARM; each bit lasts exactly one tick-to-tick interval.
- Frame length: 1+DATA_WIDTH+P+STOP_BITS ticks (P=1 with parity enabled and PARITY!=0).
- Transmit changes only on BaudTick edges, except the reset-driven return to 1.
- BaudTick in IDLE has no effect.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state and parity register built; PARITY parameter selects none/even/odd.
- Undefined: no PARITY state or logic; PARITY parameter ignored; DATA goes straight to STOP.

## Structure
- Shared package uart_pkg: FSM state enum, parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
- Sub-module tx_fifo: synchronous FIFO (DATA_WIDTH, FIFO_DEPTH), ports push/pop/data/full/empty/level, async active-low reset.
- Top holds FSM, shift register, bit counter, stop counter.

## Test plan
- Reset: assert Reset_n=0 mid-frame -> Transmit=1, Busy=0, Level=0 immediately; no residual frame after release.
- Single word 16'hA5C3, DATA_WIDTH=16, no parity, BaudTick every 8 cycles -> line: 0, bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, 1; each 8 cycles; Busy falls after stop.
- Burst of 5 words into FIFO_DEPTH=4 while idle, no pops yet -> 4 accepted, InReady=0, 5th dropped; 4 frames sent back-to-back with no idle ticks.
- Push while full on the pop cycle -> push refused, Level 4->3.
- UART_TX_PARITY_EN, PARITY=1, DATA_WIDTH=8, word 8'h07 -> parity bit 1; PARITY=2 -> 0.
- STOP_BITS=2, two queued words -> exactly 2 high ticks between frames.
